// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: two-port register-file writeback arbiter with a pending-write scoreboard.
// Port A carries ALU results and port B carries load results. One winner per cycle is
// written to the register file one cycle later. busy_vec tracks which registers still
// await a writeback, so the decode stage can detect RAW hazards through rs_busy/rt_busy.
module gpr_wb_arbiter #(
    parameter bit RR_EN = 1'b1    // 1 = round-robin, 0 = fixed priority (port A wins)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_num,
    input  logic        a_valid,
    input  logic [4:0]  a_num,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_num,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        reg_write,
    output logic [4:0]  num_write,
    output logic [31:0] data_write,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic [31:0] busy_vec
);

    logic        last_grant_b;   // 1 when port B won the most recent transfer
    logic        grant_b;
    logic        xfer;
    logic [4:0]  win_num;
    logic [31:0] win_data;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_next;

    // Pick the winning port; on a conflict round-robin favours the port not granted last.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            grant_b = RR_EN ? !last_grant_b : 1'b0;
        end else begin
            grant_b = b_valid;
        end
    end

    // Ready is suppressed during reset so nothing is accepted while state is being cleared.
    assign a_ready  = a_valid && !grant_b && !reset;
    assign b_ready  = b_valid &&  grant_b && !reset;
    assign xfer     = a_ready || b_ready;
    assign win_num  = grant_b ? b_num  : a_num;
    assign win_data = grant_b ? b_data : a_data;

    // Remember the last winner; only an actual transfer moves the round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample together.
        if (reset) begin
            last_grant_b <= 1'b1;     // A wins the first conflict after reset
        end else if (xfer) begin
            last_grant_b <= grant_b;
        end
    end

    // Register the accepted write; a write to r0 is accepted but never reaches the file.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write  <= 1'b0;
            num_write  <= 5'd0;
            data_write <= 32'd0;
        end else begin
            reg_write <= xfer && (win_num != 5'd0);
            if (xfer) begin
                num_write  <= win_num;
                data_write <= win_data;
            end
        end
    end

    // Scoreboard update: a new allocation overrides a completing write to the same register.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (alloc_valid) begin
            set_mask = 32'd1 << alloc_num;
        end
        if (reg_write) begin
            clr_mask = 32'd1 << num_write;
        end
        busy_next    = (busy_vec & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;          // r0 is hard-wired and never pending
    end

    // Pending-write bit vector, one bit per architectural register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_vec <= 32'd0;
        end else begin
            busy_vec <= busy_next;
        end
    end

    // Hazard query reads the current scoreboard only; a same-cycle writeback is not bypassed.
    assign rs_busy = busy_vec[rs];
    assign rt_busy = busy_vec[rt];

endmodule
